vid_timing_gen: RTL



---
 rtl/vid_timing_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vid_timing_gen.sv
// Raster timing generator for the pixel clock domain. Holds the raster idle until PLL lock has
// been stable for LOCK_WAIT synchronized cycles, then free-runs hsync/vsync/de and coordinates.
module vid_timing_gen #(
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned H_FP      = 24,
    parameter int unsigned H_SYNC    = 136,
    parameter int unsigned H_BP      = 160,
    parameter int unsigned V_ACTIVE  = 768,
    parameter int unsigned V_FP      = 3,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 29,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned LOCK_WAIT = 1024,
    parameter int unsigned X_W       = 11,
    parameter int unsigned Y_W       = 10
) (
    input  logic           clk_pix,
    input  logic           rst_n,
    input  logic           locked,
    output logic           running,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned WC_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [X_W-1:0]  H_LAST  = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]  H_ACT   = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]  HS_BEG  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]  HS_END  = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]  V_LAST  = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]  V_ACT   = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]  VS_BEG  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]  VS_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(LOCK_WAIT - 1);

    typedef enum logic {StWait, StRun} state_e;

    logic            r_s1, r_s2;
    state_e          r_state, w_state_d;
    logic [WC_W-1:0] r_wait_cnt, w_wait_cnt_d;
    logic [X_W-1:0]  r_h, w_h_d;
    logic [Y_W-1:0]  r_v, w_v_d;
    logic            r_de, r_hs, r_vs, r_ls, r_fs;
    logic            w_de, w_hs, w_vs, w_ls, w_fs;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= locked;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StWait;
            r_wait_cnt <= '0;
            r_h        <= '0;
            r_v        <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_h        <= w_h_d;
            r_v        <= w_v_d;
        end
    end

    // Counters stay at zero outside RUN so x/y read 0 while idle.
    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        w_h_d        = '0;
        w_v_d        = '0;
        unique case (r_state)
            StWait: begin
                if (!r_s2) begin
                    w_wait_cnt_d = '0;
                end else if (r_wait_cnt == WC_LAST) begin
                    w_state_d    = StRun;
                    w_wait_cnt_d = '0;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + WC_W'(1);
                end
            end
            StRun: begin
                if (!r_s2) begin
                    w_state_d    = StWait;
                    w_wait_cnt_d = '0;
                end else if (r_h == H_LAST) begin
                    w_h_d = '0;
                    w_v_d = (r_v == V_LAST) ? '0 : r_v + Y_W'(1);
                end else begin
                    w_h_d = r_h + X_W'(1);
                    w_v_d = r_v;
                end
            end
            default: w_state_d = StWait;
        endcase
    end

    // Decode from next-state coordinates so registered outputs line up with x/y.
    always_comb begin
        w_de = 1'b0;
        w_hs = ~HS_POL;
        w_vs = ~VS_POL;
        w_ls = 1'b0;
        w_fs = 1'b0;
        if (w_state_d == StRun) begin
            w_de = (w_h_d < H_ACT) && (w_v_d < V_ACT);
            w_hs = ((w_h_d >= HS_BEG) && (w_h_d < HS_END)) ? HS_POL : ~HS_POL;
            w_vs = ((w_v_d >= VS_BEG) && (w_v_d < VS_END)) ? VS_POL : ~VS_POL;
            w_ls = (w_h_d == '0);
            w_fs = (w_h_d == '0) && (w_v_d == '0);
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_de <= 1'b0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end else begin
            r_de <= w_de;
            r_hs <= w_hs;
            r_vs <= w_vs;
            r_ls <= w_ls;
            r_fs <= w_fs;
        end
    end

    assign running     = (r_state == StRun);
    assign x           = r_h;
    assign y           = r_v;
    assign de          = r_de;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign line_start  = r_ls;
    assign frame_start = r_fs;

endmodule
